// File: rtl/arm_pipelined_hazard_pkg.sv
// Shared types and constants for the pipelined ARM hazard unit.
// Counter width here applies to the optional HAZARD_PERF_EN build.
package arm_pipelined_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } forward_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PEND   = 2'b01,
    COMMIT = 2'b10
  } pcw_state_t;

  localparam logic [3:0] REG_PC      = 4'd15;
  localparam int         PERF_CNT_W  = 16;
  localparam int         DRAIN_DEPTH = 2;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
    return (value == {PERF_CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/arm_pipelined_forward_sel.sv
// One operand's forwarding select: Memory result beats WriteBack result,
// and reads of the PC register are never forwarded.
module arm_pipelined_forward_sel
  import arm_pipelined_hazard_pkg::*;
#(
  parameter int RegAddrWidth = 4
) (
  input  logic [RegAddrWidth-1:0] ra_execute,
  input  logic [RegAddrWidth-1:0] wa3_memory,
  input  logic [RegAddrWidth-1:0] wa3_writeback,
  input  logic                    reg_write_memory,
  input  logic                    reg_write_writeback,
  output forward_sel_t            forward_sel
);

  logic is_pc;
  logic hit_memory;
  logic hit_writeback;

  always_comb begin
    is_pc         = (ra_execute == RegAddrWidth'(REG_PC));
    hit_memory    = reg_write_memory    && (ra_execute == wa3_memory);
    hit_writeback = reg_write_writeback && (ra_execute == wa3_writeback);
    forward_sel   = FWD_NONE;
    if (!is_pc) begin
      if (hit_memory) begin
        forward_sel = FWD_MEM;
      end else if (hit_writeback) begin
        forward_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/arm_pipelined_hazard_unit.sv
// Stall/flush/forward control for the pipelined ARM core, with the register-address
// pipe and the PC-write drain FSM. Optional counters: define HAZARD_PERF_EN.
module arm_pipelined_hazard_unit
  import arm_pipelined_hazard_pkg::*;
#(
  parameter int RegAddrWidth = 4,
  parameter int DrainDepth   = DRAIN_DEPTH
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic [RegAddrWidth-1:0] i_Ra1_Decode,
  input  logic [RegAddrWidth-1:0] i_Ra2_Decode,
  input  logic [RegAddrWidth-1:0] i_Wa3_Decode,
  input  logic                    i_Mem_To_Reg_Execute,
  input  logic                    i_Reg_Write_Memory,
  input  logic                    i_Reg_Write_WriteBack,
  input  logic                    i_PC_Src_Decode,
  input  logic                    i_PC_Src_Memory,
  input  logic                    i_PC_Src_WriteBack,
  input  logic                    i_Branch_Taken_Execute,
  output logic [1:0]              o_Forward_A_Execute,
  output logic [1:0]              o_Forward_B_Execute,
  output logic                    o_Stall_Fetch,
  output logic                    o_Stall_Decode,
  output logic                    o_Flush_Decode,
  output logic                    o_Flush_Execute,
  output pcw_state_t              o_PCW_State
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]   o_Cnt_Ld_Stall,
  output logic [PERF_CNT_W-1:0]   o_Cnt_Branch_Flush,
  output logic [PERF_CNT_W-1:0]   o_Cnt_PCW_Drain
`endif
);

  localparam int CntW = $clog2(DrainDepth + 1);

  logic [RegAddrWidth-1:0] ra1_execute, ra2_execute, wa3_execute;
  logic [RegAddrWidth-1:0] wa3_memory, wa3_writeback;

  pcw_state_t      state, state_next;
  logic [CntW-1:0] cnt, cnt_next;

  logic ld_stall;
  logic pcw_enter;
  logic pcw_pend;
  logic flush_execute;
  forward_sel_t fwd_a, fwd_b;

  // Address pipe: the Decode->Execute stage is bubbled by a load-use stall or a taken branch.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      ra1_execute   <= '0;
      ra2_execute   <= '0;
      wa3_execute   <= '0;
      wa3_memory    <= '0;
      wa3_writeback <= '0;
    end else begin
      if (flush_execute) begin
        ra1_execute <= '0;
        ra2_execute <= '0;
        wa3_execute <= '0;
      end else begin
        ra1_execute <= i_Ra1_Decode;
        ra2_execute <= i_Ra2_Decode;
        wa3_execute <= i_Wa3_Decode;
      end
      wa3_memory    <= wa3_execute;
      wa3_writeback <= wa3_memory;
    end
  end

  arm_pipelined_forward_sel #(.RegAddrWidth(RegAddrWidth)) u_fwd_a (
    .ra_execute          (ra1_execute),
    .wa3_memory          (wa3_memory),
    .wa3_writeback       (wa3_writeback),
    .reg_write_memory    (i_Reg_Write_Memory),
    .reg_write_writeback (i_Reg_Write_WriteBack),
    .forward_sel         (fwd_a)
  );

  arm_pipelined_forward_sel #(.RegAddrWidth(RegAddrWidth)) u_fwd_b (
    .ra_execute          (ra2_execute),
    .wa3_memory          (wa3_memory),
    .wa3_writeback       (wa3_writeback),
    .reg_write_memory    (i_Reg_Write_Memory),
    .reg_write_writeback (i_Reg_Write_WriteBack),
    .forward_sel         (fwd_b)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt counts down the stages left before the PC-writing instruction reaches WriteBack.
  always_comb begin
    ld_stall      = i_Mem_To_Reg_Execute &&
                    ((wa3_execute == i_Ra1_Decode) || (wa3_execute == i_Ra2_Decode));
    pcw_enter     = i_PC_Src_Decode && !ld_stall && !i_Branch_Taken_Execute;
    flush_execute = ld_stall || i_Branch_Taken_Execute;
    state_next    = state;
    cnt_next      = cnt;
    case (state)
      IDLE: begin
        if (pcw_enter) begin
          state_next = PEND;
          cnt_next   = CntW'(DrainDepth);
        end
      end
      PEND: begin
        if (cnt == CntW'(1)) begin
          state_next = i_PC_Src_Memory ? COMMIT : IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt - 1'b1;
        end
      end
      COMMIT: begin
        if (pcw_enter) begin
          state_next = PEND;
          cnt_next   = CntW'(DrainDepth);
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Everything is forced quiet while reset is held, including the combinational paths.
  always_comb begin
    pcw_pend            = (state == PEND) || i_PC_Src_Decode;
    o_Forward_A_Execute = i_RESET ? FWD_NONE : fwd_a;
    o_Forward_B_Execute = i_RESET ? FWD_NONE : fwd_b;
    o_Stall_Fetch       = !i_RESET && (ld_stall || pcw_pend);
    o_Stall_Decode      = !i_RESET && ld_stall && !i_Branch_Taken_Execute;
    o_Flush_Decode      = !i_RESET && (pcw_pend || (state == COMMIT) || i_Branch_Taken_Execute);
    o_Flush_Execute     = !i_RESET && flush_execute;
    o_PCW_State         = state;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_Cnt_Ld_Stall     <= '0;
      o_Cnt_Branch_Flush <= '0;
      o_Cnt_PCW_Drain    <= '0;
    end else begin
      if (ld_stall) begin
        o_Cnt_Ld_Stall <= sat_inc(o_Cnt_Ld_Stall);
      end
      if (i_Branch_Taken_Execute) begin
        o_Cnt_Branch_Flush <= sat_inc(o_Cnt_Branch_Flush);
      end
      if (state_next == COMMIT) begin
        o_Cnt_PCW_Drain <= sat_inc(o_Cnt_PCW_Drain);
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A PC write may only retire while the drain FSM holds the instruction in WriteBack.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      assert (!i_PC_Src_WriteBack || (state == COMMIT));
    end
  end
`endif

endmodule

// File: tb/tb_arm_pipelined_hazard_unit.sv
// Directed plus randomized bench for arm_pipelined_hazard_unit against a stage-tracking model.
// Define HAZARD_PERF_EN to also check the performance counters.
module tb_arm_pipelined_hazard_unit;
  import arm_pipelined_hazard_pkg::*;

  logic       i_CLK = 1'b0;
  logic       i_RESET;
  logic [3:0] i_Ra1_Decode, i_Ra2_Decode, i_Wa3_Decode;
  logic       i_Mem_To_Reg_Execute, i_Reg_Write_Memory, i_Reg_Write_WriteBack;
  logic       i_PC_Src_Decode, i_PC_Src_Memory, i_PC_Src_WriteBack, i_Branch_Taken_Execute;
  logic [1:0] o_Forward_A_Execute, o_Forward_B_Execute;
  logic       o_Stall_Fetch, o_Stall_Decode, o_Flush_Decode, o_Flush_Execute;
  pcw_state_t o_PCW_State;
`ifdef HAZARD_PERF_EN
  logic [15:0] o_Cnt_Ld_Stall, o_Cnt_Branch_Flush, o_Cnt_PCW_Drain;
`endif

  always #5 i_CLK = ~i_CLK;

  arm_pipelined_hazard_unit dut (
    .i_CLK                  (i_CLK),
    .i_RESET                (i_RESET),
    .i_Ra1_Decode           (i_Ra1_Decode),
    .i_Ra2_Decode           (i_Ra2_Decode),
    .i_Wa3_Decode           (i_Wa3_Decode),
    .i_Mem_To_Reg_Execute   (i_Mem_To_Reg_Execute),
    .i_Reg_Write_Memory     (i_Reg_Write_Memory),
    .i_Reg_Write_WriteBack  (i_Reg_Write_WriteBack),
    .i_PC_Src_Decode        (i_PC_Src_Decode),
    .i_PC_Src_Memory        (i_PC_Src_Memory),
    .i_PC_Src_WriteBack     (i_PC_Src_WriteBack),
    .i_Branch_Taken_Execute (i_Branch_Taken_Execute),
    .o_Forward_A_Execute    (o_Forward_A_Execute),
    .o_Forward_B_Execute    (o_Forward_B_Execute),
    .o_Stall_Fetch          (o_Stall_Fetch),
    .o_Stall_Decode         (o_Stall_Decode),
    .o_Flush_Decode         (o_Flush_Decode),
    .o_Flush_Execute        (o_Flush_Execute),
    .o_PCW_State            (o_PCW_State)
`ifdef HAZARD_PERF_EN
    ,
    .o_Cnt_Ld_Stall         (o_Cnt_Ld_Stall),
    .o_Cnt_Branch_Flush     (o_Cnt_Branch_Flush),
    .o_Cnt_PCW_Drain        (o_Cnt_PCW_Drain)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: which register each in-flight instruction reads/writes, and where the
  // PC-writing instruction is (0 none, 1 Execute, 2 Memory, 3 WriteBack).
  logic [3:0] m_ra1_e, m_ra2_e, m_wa3_e, m_wa3_m, m_wa3_w;
  int         m_pcw_loc;
  int         m_cnt_ld, m_cnt_br, m_cnt_pcw;
  logic [7:0] exp_q[$];

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (i_Reg_Write_Memory && ra == m_wa3_m) return 2'b10;
    if (i_Reg_Write_WriteBack && ra == m_wa3_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_ld();
    return i_Mem_To_Reg_Execute && (m_wa3_e == i_Ra1_Decode || m_wa3_e == i_Ra2_Decode);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Settle the current inputs and compare every output with the model.
  task automatic eval_cycle();
    logic       ld, br, pend, e_sf, e_sd, e_fd, e_fe;
    logic [1:0] e_fa, e_fb;
    logic [7:0] e;
    pcw_state_t e_state;
    i_PC_Src_WriteBack = !i_RESET && (m_pcw_loc == 3);
    #1;
    ld   = ref_ld();
    br   = i_Branch_Taken_Execute;
    pend = (m_pcw_loc == 1) || (m_pcw_loc == 2) || i_PC_Src_Decode;
    if (i_RESET) begin
      e_fa = 2'b00; e_fb = 2'b00;
      e_sf = 1'b0; e_sd = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
    end else begin
      e_fa = ref_fwd(m_ra1_e);
      e_fb = ref_fwd(m_ra2_e);
      e_sf = ld || pend;
      e_sd = ld && !br;
      e_fd = pend || (m_pcw_loc == 3) || br;
      e_fe = ld || br;
    end
    exp_q.push_back({e_fa, e_fb, e_sf, e_sd, e_fd, e_fe});
    e = exp_q.pop_front();
    chk("fwd_a", 16'(o_Forward_A_Execute), 16'(e[7:6]));
    chk("fwd_b", 16'(o_Forward_B_Execute), 16'(e[5:4]));
    chk("stall_fetch", 16'(o_Stall_Fetch), 16'(e[3]));
    chk("stall_decode", 16'(o_Stall_Decode), 16'(e[2]));
    chk("flush_decode", 16'(o_Flush_Decode), 16'(e[1]));
    chk("flush_execute", 16'(o_Flush_Execute), 16'(e[0]));
    if (!i_RESET) begin
      e_state = (m_pcw_loc == 0) ? IDLE : (m_pcw_loc == 3) ? COMMIT : PEND;
      chk("pcw_state", 16'(o_PCW_State), 16'(e_state));
    end
  endtask

  // Clock edge: move the model's instructions one stage along.
  task automatic advance();
    logic ld, br, enter;
    @(posedge i_CLK);
    ld    = ref_ld();
    br    = i_Branch_Taken_Execute;
    enter = i_PC_Src_Decode && !ld && !br;
    if (i_RESET) begin
      m_ra1_e = 0; m_ra2_e = 0; m_wa3_e = 0; m_wa3_m = 0; m_wa3_w = 0;
      m_pcw_loc = 0; m_cnt_ld = 0; m_cnt_br = 0; m_cnt_pcw = 0;
    end else begin
      if (ld) m_cnt_ld++;
      if (br) m_cnt_br++;
      if (m_pcw_loc == 2 && i_PC_Src_Memory) m_cnt_pcw++;
      case (m_pcw_loc)
        1:       m_pcw_loc = 2;
        2:       m_pcw_loc = i_PC_Src_Memory ? 3 : 0;
        default: m_pcw_loc = enter ? 1 : 0;
      endcase
      m_wa3_w = m_wa3_m;
      m_wa3_m = m_wa3_e;
      if (ld || br) begin
        m_ra1_e = 0; m_ra2_e = 0; m_wa3_e = 0;
      end else begin
        m_ra1_e = i_Ra1_Decode; m_ra2_e = i_Ra2_Decode; m_wa3_e = i_Wa3_Decode;
      end
    end
    @(negedge i_CLK);
  endtask

  task automatic step();
    eval_cycle();
    advance();
  endtask

  task automatic set_d(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] w);
    i_Ra1_Decode = r1; i_Ra2_Decode = r2; i_Wa3_Decode = w;
  endtask

  task automatic clr_ctl();
    i_Mem_To_Reg_Execute = 0; i_Reg_Write_Memory = 0; i_Reg_Write_WriteBack = 0;
    i_PC_Src_Decode = 0; i_PC_Src_Memory = 0; i_Branch_Taken_Execute = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    i_RESET = 1; i_PC_Src_WriteBack = 0;
    set_d(0, 0, 0); clr_ctl();
    m_ra1_e = 0; m_ra2_e = 0; m_wa3_e = 0; m_wa3_m = 0; m_wa3_w = 0;
    m_pcw_loc = 0; m_cnt_ld = 0; m_cnt_br = 0; m_cnt_pcw = 0;
    @(negedge i_CLK);
    // Reset with noisy inputs: all outputs must stay low.
    set_d(1, 1, 1); i_PC_Src_Decode = 1; i_Branch_Taken_Execute = 1;
    step();
    set_d(0, 0, 0); clr_ctl();
    step();
    i_RESET = 0;

    // ADD R1 followed by a reader of R1.
    set_d(0, 0, 1); step();
    set_d(1, 6, 4); step();
    set_d(7, 8, 5); i_Reg_Write_Memory = 1;
    eval_cycle(); chk("add_fwd_mem", 16'(o_Forward_A_Execute), 16'h2); advance();
    set_d(0, 0, 0); i_Reg_Write_Memory = 0; i_Reg_Write_WriteBack = 1;
    eval_cycle(); chk("add_fwd_gone", 16'(o_Forward_A_Execute), 16'h0); advance();
    clr_ctl();

    // R2 written in both Memory and WriteBack; PC register never forwards.
    set_d(0, 0, 2); step();
    set_d(0, 0, 2); step();
    set_d(15, 2, 15); step();
    set_d(15, 0, 0); i_Reg_Write_Memory = 1; i_Reg_Write_WriteBack = 1;
    eval_cycle(); chk("both_fwd_b_mem", 16'(o_Forward_B_Execute), 16'h2); advance();
    set_d(0, 0, 0);
    eval_cycle(); chk("pc_no_fwd", 16'(o_Forward_A_Execute), 16'h0); advance();
    clr_ctl();

    // LDR R3 followed by a user of R3.
    set_d(0, 0, 3); step();
    set_d(3, 0, 9); i_Mem_To_Reg_Execute = 1;
    eval_cycle();
    chk("ld_stall_fetch", 16'(o_Stall_Fetch), 16'h1);
    chk("ld_stall_decode", 16'(o_Stall_Decode), 16'h1);
    chk("ld_flush_exec", 16'(o_Flush_Execute), 16'h1);
    advance();
    i_Mem_To_Reg_Execute = 0;
    eval_cycle(); chk("ld_released", 16'(o_Stall_Fetch), 16'h0); advance();
    set_d(0, 0, 0); i_Reg_Write_WriteBack = 1;
    eval_cycle(); chk("ld_fwd_wb", 16'(o_Forward_A_Execute), 16'h1); advance();
    clr_ctl();

    // Taken branch together with a load-use stall: flush wins.
    set_d(0, 0, 3); step();
    set_d(3, 0, 0); i_Mem_To_Reg_Execute = 1; i_Branch_Taken_Execute = 1;
    eval_cycle();
    chk("br_ld_flush_dec", 16'(o_Flush_Decode), 16'h1);
    chk("br_ld_flush_exe", 16'(o_Flush_Execute), 16'h1);
    chk("br_ld_stall_dec", 16'(o_Stall_Decode), 16'h0);
    advance();
    clr_ctl(); set_d(0, 0, 0); step();

    // MOV PC whose condition passes: 3 fetch stalls, 4 decode flushes.
    for (int c = 0; c < 5; c++) begin
      i_PC_Src_Decode = (c == 0);
      i_PC_Src_Memory = (c == 2);
      eval_cycle();
      chk("movpc_stall_f", 16'(o_Stall_Fetch), (c < 3) ? 16'h1 : 16'h0);
      chk("movpc_flush_d", 16'(o_Flush_Decode), (c < 4) ? 16'h1 : 16'h0);
      advance();
    end
    chk("movpc_idle", 16'(o_PCW_State), 16'(IDLE));
    clr_ctl();

    // MOV PC whose condition fails in Memory: drain aborts, no COMMIT.
    for (int c = 0; c < 4; c++) begin
      i_PC_Src_Decode = (c == 0);
      eval_cycle();
      chk("abort_stall_f", 16'(o_Stall_Fetch), (c < 3) ? 16'h1 : 16'h0);
      chk("abort_flush_d", 16'(o_Flush_Decode), (c < 3) ? 16'h1 : 16'h0);
      advance();
    end
    clr_ctl();

    // Reset in the middle of a drain abandons it.
    i_PC_Src_Decode = 1; step();
    i_PC_Src_Decode = 0; step();
    i_RESET = 1; step();
    i_RESET = 0;
    eval_cycle(); chk("reset_drain", 16'(o_PCW_State), 16'(IDLE)); advance();

    // Randomized traffic; the WriteBack PC strobe follows the protocol.
    for (int n = 0; n < 600; n++) begin
      i_RESET                = ($urandom_range(0, 99) == 0);
      set_d(rnd_reg(), rnd_reg(), rnd_reg());
      i_Mem_To_Reg_Execute   = ($urandom_range(0, 3) == 0);
      i_Reg_Write_Memory     = 1'($urandom_range(0, 1));
      i_Reg_Write_WriteBack  = 1'($urandom_range(0, 1));
      i_PC_Src_Decode        = ($urandom_range(0, 5) == 0);
      i_PC_Src_Memory        = ($urandom_range(0, 3) != 0);
      i_Branch_Taken_Execute = ($urandom_range(0, 7) == 0);
      step();
    end
    i_RESET = 0; clr_ctl();
    step();

`ifdef HAZARD_PERF_EN
    chk("cnt_ld", o_Cnt_Ld_Stall, 16'(m_cnt_ld));
    chk("cnt_br", o_Cnt_Branch_Flush, 16'(m_cnt_br));
    chk("cnt_pcw", o_Cnt_PCW_Drain, 16'(m_cnt_pcw));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
